// File: rtl/mode_machine.sv
// mode_machine: mode-selected frame source for a downstream serializer.
//
// A 2-bit mode register picks one of four frame sources. The outputs are
// registered from the mode held before the edge, so a mode change shows at
// the outputs one cycle after the mode register takes it.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   changeMode in   1   level enable: load modeSet into the mode register
//   modeSet    in   2   requested mode (00 BASE, 01 RBSWAP, 10 CYCLE, 11 BLANK)
//   send       in   1   manual transmit request, honoured in BASE only
//   Green/Red/Blue in 4 base-mode colour nibbles
//   rbSwap     in  96   precomputed frame for RBSWAP
//   colorCycle in  96   precomputed frame for CYCLE
//   go         out  1   registered transmit request
//   regVal     out 96   registered frame, pixel 7 in [95:84] .. pixel 0 in [11:0]

// pixelLane: holds one 12-bit pixel of the output frame and selects its
// next value from the current mode.
module pixelLane (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [11:0] basePix,
  input  logic [11:0] rbPix,
  input  logic [11:0] ccPix,
  output logic [11:0] pixQ
);
  logic [11:0] pixNext;

  always_comb begin
    pixNext = '0;
    case (mode)
      2'b00:   pixNext = basePix;
      2'b01:   pixNext = rbPix;
      2'b10:   pixNext = ccPix;
      default: pixNext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pixQ <= '0;
    else        pixQ <= pixNext;
  end
endmodule

module mode_machine (
  input  logic        clk,
  input  logic        reset,
  input  logic        changeMode,
  input  logic [1:0]  modeSet,
  input  logic        send,
  input  logic [3:0]  Green,
  input  logic [3:0]  Red,
  input  logic [3:0]  Blue,
  input  logic [95:0] rbSwap,
  input  logic [95:0] colorCycle,
  output logic        go,
  output logic [95:0] regVal
);
  localparam int NUM_LANES = 8;
  localparam int PIX_W     = 12;

  typedef enum logic [1:0] {
    BASE   = 2'b00,
    RBSWAP = 2'b01,
    CYCLE  = 2'b10,
    BLANK  = 2'b11
  } mode_t;

  mode_t modeQ, modeNext;
  logic  goNext;

  logic [NUM_LANES-1:0][PIX_W-1:0] rbPix, ccPix, pixQ;
  logic [PIX_W-1:0]                basePix;

  assign rbPix   = rbSwap;
  assign ccPix   = colorCycle;
  assign basePix = {Green, Red, Blue};

  // Mode register. Reloading the current mode is harmless: same value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) modeQ <= BASE;
    else        modeQ <= modeNext;
  end

  // Next mode and next go both come from the pre-edge mode, which is what
  // gives outputs their one-cycle lag behind the mode register.
  always_comb begin
    modeNext = modeQ;
    goNext   = 1'b1;
    if (changeMode) modeNext = mode_t'(modeSet);
    if (modeQ == BASE) goNext = send;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) go <= 1'b0;
    else        go <= goNext;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : gLane
      pixelLane lane (
        .clk     (clk),
        .reset   (reset),
        .mode    (modeQ),
        .basePix (basePix),
        .rbPix   (rbPix[i]),
        .ccPix   (ccPix[i]),
        .pixQ    (pixQ[i])
      );
    end
  endgenerate

  assign regVal = pixQ;
endmodule

// File: tb/tb_mode_machine.sv
// Scoreboard bench for mode_machine: the stimulus process drives inputs on
// the falling edge and pushes the expected post-edge outputs computed from a
// mode-level reference model; the monitor pops and compares after each
// rising edge.
module tb_mode_machine;
  logic        clk = 1'b0;
  logic        reset, changeMode, send, go;
  logic [1:0]  modeSet;
  logic [3:0]  Green, Red, Blue;
  logic [95:0] rbSwap, colorCycle, regVal;

  typedef struct {
    logic        go;
    logic [95:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mMode  = 0;   // reference mode: 0 base, 1 rbswap, 2 cycle, 3 blank

  always #5 clk = ~clk;

  mode_machine dut (
    .clk        (clk),
    .reset      (reset),
    .changeMode (changeMode),
    .modeSet    (modeSet),
    .send       (send),
    .Green      (Green),
    .Red        (Red),
    .Blue       (Blue),
    .rbSwap     (rbSwap),
    .colorCycle (colorCycle),
    .go         (go),
    .regVal     (regVal)
  );

  function automatic logic [95:0] baseFrame(input logic [3:0] g, r, b);
    logic [95:0] f;
    for (int k = 0; k < 8; k++) f[k*12 +: 12] = {g, r, b};
    return f;
  endfunction

  task automatic checkZero(input string name);
    checks++;
    if (go !== 1'b0 || regVal !== 96'h0) begin
      errors++;
      $display("FAIL %s: go=%b regVal=%h, want go=0 regVal=0", name, go, regVal);
    end
  endtask

  task automatic drive(input logic cm, input logic [1:0] ms, input logic snd,
                       input logic [3:0] g, r, b, input logic [95:0] rb, cc);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    changeMode = cm; modeSet = ms; send = snd;
    Green = g; Red = r; Blue = b; rbSwap = rb; colorCycle = cc;
    case (mMode)
      0:       begin e.go = snd;  e.val = baseFrame(g, r, b); end
      1:       begin e.go = 1'b1; e.val = rb; end
      2:       begin e.go = 1'b1; e.val = cc; end
      default: begin e.go = 1'b1; e.val = 96'h0; end
    endcase
    q.push_back(e);
    if (cm) mMode = int'(ms);
  endtask

  // Reset pulled low between clock edges: outputs must clear without an edge.
  task automatic midReset();
    @(negedge clk);
    #2 reset = 1'b0;
    mMode = 0;
    #1 checkZero("resetMid");
  endtask

  task automatic randDrive();
    drive(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
          4'($urandom), 4'($urandom), 4'($urandom),
          {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        checkZero("resetHold");
      end else if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL queueUnderflow: output at %0t with no expectation", $time);
      end else begin
        e = q.pop_front();
        checks++;
        if (go !== e.go || regVal !== e.val) begin
          errors++;
          $display("FAIL frame: go=%b regVal=%h, want go=%b regVal=%h",
                   go, regVal, e.go, e.val);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [95:0] rbK, ccK;
    rbK = 96'hBEEDADBEEDADBEEDADBEEDAD;
    ccK = 96'hCABFADCABFADCABFADCABFAD;
    reset = 1'b0; changeMode = 1'b0; modeSet = 2'b00; send = 1'b0;
    Green = 4'h0; Red = 4'h0; Blue = 4'h0; rbSwap = '0; colorCycle = '0;
    #1 checkZero("resetAsync");

    // BASE with send, then send dropped
    drive(0, 2'b00, 1, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(0, 2'b00, 0, 4'hA, 4'hB, 4'hC, rbK, ccK);
    // modeSet=01 without changeMode: stays BASE
    repeat (3) drive(0, 2'b01, 1, 4'hA, 4'hB, 4'hC, rbK, ccK);
    // RBSWAP load, then hold with changeMode dropped and send=0
    drive(1, 2'b01, 0, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(0, 2'b01, 0, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(0, 2'b00, 0, 4'h1, 4'h2, 4'h3, rbK, ccK);
    // CYCLE then BLANK
    drive(1, 2'b10, 0, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(0, 2'b10, 0, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(1, 2'b11, 1, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(1, 2'b11, 0, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(0, 2'b11, 0, 4'hF, 4'hF, 4'hF, rbK, ccK);
    // back to CYCLE, reset mid-mode, resume in BASE
    drive(1, 2'b10, 1, 4'hA, 4'hB, 4'hC, rbK, ccK);
    drive(0, 2'b10, 1, 4'hA, 4'hB, 4'hC, rbK, ccK);
    midReset();
    drive(0, 2'b10, 1, 4'h5, 4'h6, 4'h7, rbK, ccK);
    drive(0, 2'b10, 0, 4'h5, 4'h6, 4'h7, rbK, ccK);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) midReset();
      randDrive();
    end

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
